camera_tx_gen: RTL
==================

CAMERA_TX_GEN -- requirements
Module: camera_tx_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  system clock; rstn_i  in  1  synchronous active-low reset.
REQ-002 The block SHALL have the configuration port: cfg_data_i in 32; cfg_addr_i in 5; cfg_valid_i in 1; cfg_rwn_i in 1 (1=read); cfg_data_o out 32; cfg_ready_o out 1.
REQ-003 The block SHALL have the pixel source port: pix_data_i in 16; pix_valid_i in 1; pix_ready_o out 1 (a pixel is consumed when pix_valid_i & pix_ready_o).
REQ-004 The block SHALL have the camera port: cam_pclk_o out 1; cam_vsync_o out 1; cam_href_o out 1; cam_data_o out 8.

Function
REQ-005 Registers SHALL be word-indexed by cfg_addr_i; writes occur when cfg_valid_i & ~cfg_rwn_i; cfg_ready_o SHALL be constant 1; read data is combinational; unmapped reads return 0.
REQ-006 Address 0 CTRL (RW, reset 0): bit0 en, bit1 continuous, bit2 vsync_pol, bit3 href_pol, bit4 fmt (0=8-bit, 1 byte/pixel from pix_data_i[7:0]; 1=16-bit, 2 bytes/pixel, [15:8] first).
REQ-007 Address 1 SIZE (RW, reset 0): [15:0] width in pixels, [31:16] height in lines.
REQ-008 Address 2 TIMING (RW, reset 0x0004_0002): [7:0] vsync_len, [15:8] vblank, [23:16] hblank, all in pclk periods; a field value of 0 SHALL be treated as 1.
REQ-009 Address 3 STATUS: bit0 busy (RO), bit1 underrun (sticky, write 1 to clear), [31:16] frame count (RO, wraps 0xFFFF->0, cleared by a write with bit2=1).
REQ-010 cam_pclk_o SHALL toggle every clk cycle while busy and rest at 0 when idle; a "tick" is the clk cycle in which cam_pclk_o is 1 (it falls at the end); cam_vsync_o, cam_href_o, cam_data_o and the state SHALL change only at the end of a tick.
REQ-011 States: IDLE, VSYNC, VBLANK, LINE, HBLANK.
REQ-012 IDLE->VSYNC when en=1, width!=0 and height!=0; SIZE, TIMING and fmt SHALL be shadowed at that transition; with width or height 0 the block SHALL stay IDLE.
REQ-013 VSYNC: vsync active for vsync_len ticks, then VBLANK for vblank ticks, then LINE.
REQ-014 LINE: href active; exactly width (fmt=0) or 2*width (fmt=1) bytes, one per tick; then HBLANK for hblank ticks, then LINE again or, after the last line, end-of-frame.
REQ-015 End-of-frame SHALL increment frame count; if en & continuous, go to VSYNC (reshadowing); otherwise clear en and go to IDLE.
REQ-016 Clearing en mid-frame SHALL let the current frame complete; register writes during a frame SHALL affect only the next frame.
REQ-017 Active level of vsync/href SHALL be high when the polarity bit is 0 and low when it is 1; inactive outputs SHALL drive the inverse level; polarity SHALL be taken live from CTRL.
REQ-018 pix_ready_o SHALL be 1 only in a tick in LINE where a new pixel is needed (every byte for fmt=0, first byte of each pixel for fmt=1).
REQ-019 fmt=1: the low byte SHALL be held internally and output on the following tick without a pixel request.
REQ-020 Underrun: if a pixel is needed and pix_valid_i=0, the block SHALL output 0x00 for that pixel's bytes, set underrun and continue timing unchanged.
REQ-021 cam_data_o SHALL be 0x00 outside LINE.
REQ-022 busy SHALL be 1 in every state except IDLE.

Reset
REQ-023 With rstn_i low at a clk edge, all registers SHALL take reset values, the state SHALL become IDLE, and outputs SHALL be cam_pclk_o=0, cam_vsync_o=0, cam_href_o=0, cam_data_o=0, pix_ready_o=0, cfg_data_o combinational from reset registers.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no frame count increment.

Verification
REQ-025 SIZE=0x0002_0003, TIMING=0x0001_0101, CTRL=0x1 -> 1 vsync tick, 1 vblank tick, 2 lines of 3 bytes href high, 1 hblank tick; frame count=1; en reads 0.
REQ-026 fmt=1, width=2, height=1, pixels 0xA1B2, 0xC3D4 -> bytes B? no: A1, B2, C3, D4 on consecutive ticks; exactly 2 handshakes.
REQ-027 pix_valid_i held 0 for the 2nd pixel, width=3 -> bytes p0, 00, p2; underrun=1; W1C of STATUS bit1 clears it.
REQ-028 CTRL=0xF (continuous, both polarities inverted) -> idle vsync/href drive 1, active 0; frames repeat; writing en=0 mid-frame -> frame finishes, then IDLE, cam_pclk_o=0.
REQ-029 Write SIZE during frame 1 in continuous mode -> frame 1 keeps the old geometry, frame 2 uses the new geometry.
REQ-030 Assert rstn_i mid-LINE -> next cycle all outputs 0, CTRL=0, frame count unchanged at 0.

Source files
------------

// File: rtl/camera_tx_gen.sv
// camera_tx_gen: parallel camera (DVP-style) transmitter pattern source.
//
// Ports:
//   clk_i, rstn_i            system clock, synchronous active-low reset
//   cfg_*                    word-addressed register port (CTRL, SIZE, TIMING, STATUS);
//                            cfg_ready_o is always 1, read data is combinational
//   pix_data_i/valid_i/ready_o  pixel source handshake (consumed on valid & ready)
//   cam_pclk_o/vsync_o/href_o/data_o  camera output bus
//
// The frame FSM advances once per "tick" (the clk cycle with cam_pclk_o high). The
// camera pins are registered at the end of each tick from the state of that tick, so
// the pins show each tick's values for the following pclk period and only change on
// the falling edge of pclk.
module camera_tx_gen (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] cfg_data_i,
   input  logic [4:0]  cfg_addr_i,
   input  logic        cfg_valid_i,
   input  logic        cfg_rwn_i,
   output logic [31:0] cfg_data_o,
   output logic        cfg_ready_o,
   input  logic [15:0] pix_data_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic        cam_pclk_o,
   output logic        cam_vsync_o,
   output logic        cam_href_o,
   output logic [7:0]  cam_data_o
);

   typedef enum logic [2:0] {StIdle, StVsync, StVblank, StLine, StHblank} state_e;

   state_e      state_q, state_d;
   logic [16:0] cnt_q, cnt_d;
   logic [15:0] line_q, line_d;
   logic        pclk_q, pclk_d;

   logic [4:0]  ctrl_q, ctrl_d;
   logic [31:0] size_q, size_d;
   logic [23:0] timing_q, timing_d;
   logic        underrun_q, underrun_d;
   logic [15:0] fcnt_q, fcnt_d;

   logic [15:0] sh_w_q, sh_h_q;
   logic [7:0]  sh_vs_q, sh_vb_q, sh_hb_q;
   logic        sh_fmt_q;

   logic        vs_act_q, href_act_q;
   logic [7:0]  data_q, low_q;

   logic        wr, tick, busy, start_ok, need, load_shadow, eof;
   logic [16:0] line_bytes;
   logic [7:0]  vs_len, vb_len, hb_len, byte_out;

   // A programmed length of 0 behaves as 1.
   function automatic logic [7:0] eff_len(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

   assign wr          = cfg_valid_i & ~cfg_rwn_i;
   assign cfg_ready_o = 1'b1;
   assign busy        = (state_q != StIdle);
   assign tick        = pclk_q;
   assign start_ok    = ctrl_q[0] & (|size_q[15:0]) & (|size_q[31:16]);
   assign vs_len      = eff_len(sh_vs_q);
   assign vb_len      = eff_len(sh_vb_q);
   assign hb_len      = eff_len(sh_hb_q);
   assign line_bytes  = sh_fmt_q ? {sh_w_q, 1'b0} : {1'b0, sh_w_q};
   // In 16-bit mode only even byte slots fetch a pixel; odd slots replay the held low byte.
   assign need        = (state_q == StLine) & (~sh_fmt_q | ~cnt_q[0]);
   assign pix_ready_o = tick & need;
   assign pclk_d      = busy ? ~pclk_q : 1'b0;

   assign cam_pclk_o  = pclk_q;
   assign cam_vsync_o = vs_act_q ^ ctrl_q[2];
   assign cam_href_o  = href_act_q ^ ctrl_q[3];
   assign cam_data_o  = data_q;

   always_comb begin
      byte_out = low_q;
      if (need) begin
         if (!pix_valid_i)  byte_out = 8'h00;
         else if (sh_fmt_q) byte_out = pix_data_i[15:8];
         else               byte_out = pix_data_i[7:0];
      end
   end

   // Frame sequencing.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      load_shadow = 1'b0;
      eof         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d     = StVsync;
               cnt_d       = '0;
               load_shadow = 1'b1;
            end
         end
         StVsync: begin
            if (tick) begin
               if (cnt_q == 17'(vs_len - 8'd1)) begin
                  state_d = StVblank;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 17'd1;
               end
            end
         end
         StVblank: begin
            if (tick) begin
               if (cnt_q == 17'(vb_len - 8'd1)) begin
                  state_d = StLine;
                  cnt_d   = '0;
                  line_d  = '0;
               end else begin
                  cnt_d = cnt_q + 17'd1;
               end
            end
         end
         StLine: begin
            if (tick) begin
               if (cnt_q == line_bytes - 17'd1) begin
                  state_d = StHblank;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 17'd1;
               end
            end
         end
         StHblank: begin
            if (tick) begin
               if (cnt_q == 17'(hb_len - 8'd1)) begin
                  cnt_d = '0;
                  if (line_q == sh_h_q - 16'd1) begin
                     eof = 1'b1;
                     if (start_ok && ctrl_q[1]) begin
                        state_d     = StVsync;
                        load_shadow = 1'b1;
                     end else begin
                        state_d = StIdle;
                     end
                  end else begin
                     line_d  = line_q + 16'd1;
                     state_d = StLine;
                  end
               end else begin
                  cnt_d = cnt_q + 17'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Register file next state.
   always_comb begin
      ctrl_d     = ctrl_q;
      size_d     = size_q;
      timing_d   = timing_q;
      underrun_d = underrun_q;
      fcnt_d     = fcnt_q;
      if (eof) begin
         fcnt_d = fcnt_q + 16'd1;
         if (!(start_ok && ctrl_q[1])) ctrl_d[0] = 1'b0;
      end
      if (wr) begin
         case (cfg_addr_i)
            5'd0: ctrl_d   = cfg_data_i[4:0];
            5'd1: size_d   = cfg_data_i;
            5'd2: timing_d = cfg_data_i[23:0];
            5'd3: begin
               if (cfg_data_i[1]) underrun_d = 1'b0;
               if (cfg_data_i[2]) fcnt_d = '0;
            end
            default: ;
         endcase
      end
      // A new underrun event is never lost to a simultaneous clear.
      if (tick && need && !pix_valid_i) underrun_d = 1'b1;
   end

   always_comb begin
      cfg_data_o = '0;
      case (cfg_addr_i)
         5'd0: cfg_data_o = {27'd0, ctrl_q};
         5'd1: cfg_data_o = size_q;
         5'd2: cfg_data_o = {8'd0, timing_q};
         5'd3: cfg_data_o = {fcnt_q, 14'd0, underrun_q, busy};
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         line_q     <= '0;
         pclk_q     <= 1'b0;
         ctrl_q     <= '0;
         size_q     <= '0;
         timing_q   <= 24'h04_0002;
         underrun_q <= 1'b0;
         fcnt_q     <= '0;
         sh_w_q     <= '0;
         sh_h_q     <= '0;
         sh_vs_q    <= '0;
         sh_vb_q    <= '0;
         sh_hb_q    <= '0;
         sh_fmt_q   <= 1'b0;
         vs_act_q   <= 1'b0;
         href_act_q <= 1'b0;
         data_q     <= '0;
         low_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         line_q     <= line_d;
         pclk_q     <= pclk_d;
         ctrl_q     <= ctrl_d;
         size_q     <= size_d;
         timing_q   <= timing_d;
         underrun_q <= underrun_d;
         fcnt_q     <= fcnt_d;
         if (load_shadow) begin
            sh_w_q   <= size_q[15:0];
            sh_h_q   <= size_q[31:16];
            sh_vs_q  <= timing_q[7:0];
            sh_vb_q  <= timing_q[15:8];
            sh_hb_q  <= timing_q[23:16];
            sh_fmt_q <= ctrl_q[4];
         end
         if (tick) begin
            vs_act_q   <= (state_q == StVsync);
            href_act_q <= (state_q == StLine);
            data_q     <= (state_q == StLine) ? byte_out : 8'h00;
            if (need && sh_fmt_q) low_q <= pix_valid_i ? pix_data_i[7:0] : 8'h00;
         end
      end
   end

endmodule
